// File: rtl/candy_sram_ctrl_pkg.sv
// Shared definitions for the fetch-to-SRAM responder.
// Provides the controller state encoding, the SRAM address/data widths and the
// request/response level constants used by candy_sram_ctrl and its bench.
package candy_sram_ctrl_pkg;

  localparam int unsigned SramAddWidth  = 17;
  localparam int unsigned SramDataWidth = 24;

  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadReady    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [2:0] {
    SramIdle    = 3'd0,
    SramRead    = 3'd1,
    SramWrite   = 3'd2,
    SramWHold   = 3'd3,
    SramRecover = 3'd4
  } sram_state_e;

endpackage

// File: rtl/candy_sram_ctrl.sv
// Responder for the internal SRAM request interface; sole driver of the
// external asynchronous SRAM pins.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   sram_read_enable    read request level (sampled only in IDLE)
//   sram_write_enable   write request level (wins over read in IDLE)
//   sram_addr/wdata     request address / write data (latched on acceptance)
//   sram_data           registered read data, held until the next read
//   data_ready          one-cycle pulse while sram_data is fresh
//   write_done          one-cycle pulse when a write finishes
//   busy                high whenever the controller is not idle
//   mem_*               external SRAM address, data bus and strobes
//
// Access shape: READ/WRITE last WAIT_CYCLES+1 cycles, writes add a WHOLD cycle
// of data hold, and every access ends in RECOVER so the bus turns around with
// all strobes released.
module candy_sram_ctrl
  import candy_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sram_read_enable,
  input  logic                     sram_write_enable,
  input  logic [SramAddWidth-1:0]  sram_addr,
  input  logic [SramDataWidth-1:0] sram_wdata,
  output logic [SramDataWidth-1:0] sram_data,
  output logic                     data_ready,
  output logic                     write_done,
  output logic                     busy,
  output logic [SramAddWidth-1:0]  mem_addr,
  inout  wire  [SramDataWidth-1:0] mem_dq,
  output logic                     mem_ce_n,
  output logic                     mem_oe_n,
  output logic                     mem_we_n
);

  sram_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SramAddWidth-1:0]  addr_q, addr_d;
  logic [SramDataWidth-1:0] wdata_q, wdata_d;
  logic [SramDataWidth-1:0] rdata_q, rdata_d;
  logic data_ready_q, data_ready_d;
  logic write_done_q, write_done_d;
  logic busy_q, busy_d;
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic drive_q, drive_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    data_ready_d = 1'b0;
    write_done_d = 1'b0;

    unique case (state_q)
      SramIdle: begin
        if (sram_write_enable == WriteEnable) begin
          addr_d  = sram_addr;
          wdata_d = sram_wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = SramWrite;
        end else if (sram_read_enable == ReadEnable) begin
          addr_d  = sram_addr;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = SramRead;
        end
      end
      SramRead: begin
        if (cnt_q == '0) begin
          rdata_d      = mem_dq;
          data_ready_d = ReadReady;
          state_d      = SramRecover;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SramWrite: begin
        if (cnt_q == '0) begin
          state_d = SramWHold;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SramWHold: begin
        write_done_d = 1'b1;
        state_d      = SramRecover;
      end
      SramRecover: state_d = SramIdle;
      default:     state_d = SramIdle;
    endcase

    // Strobes are decoded from the next state so they are registered yet
    // line up exactly with the state they belong to.
    ce_n_d  = !((state_d == SramRead) || (state_d == SramWrite) || (state_d == SramWHold));
    oe_n_d  = (state_d != SramRead);
    we_n_d  = (state_d != SramWrite);
    drive_d = (state_d == SramWrite) || (state_d == SramWHold);
    busy_d  = (state_d != SramIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SramIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      data_ready_q <= 1'b0;
      write_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      drive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      data_ready_q <= data_ready_d;
      write_done_q <= write_done_d;
      busy_q       <= busy_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      drive_q      <= drive_d;
    end
  end

  // Only WRITE/WHOLD drive the bus; READ and RECOVER always separate the two
  // directions, so the SRAM and this block never fight.
  assign mem_dq = drive_q ? wdata_q : {SramDataWidth{1'bz}};

  assign sram_data  = rdata_q;
  assign data_ready = data_ready_q;
  assign write_done = write_done_q;
  assign busy       = busy_q;
  assign mem_addr   = addr_q;
  assign mem_ce_n   = ce_n_q;
  assign mem_oe_n   = oe_n_q;
  assign mem_we_n   = we_n_q;

endmodule
